// File: rtl/ac_sequencer.sv
// ac_sequencer
//   Runs one dot-product accumulation on the 24-bit AC register per command:
//   initialise AC (clear or preload), accept `len` operand pairs over a
//   valid/ready handshake pulsing AC's load-from-ALU strobe once per pair,
//   then latch the final AC value into `result` and pulse `done`.
//   This block is the only driver of AC's control pins.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   start, len,       command strobe (IDLE only) with pair count,
//   init_en, init_val init mode (1 = preload init_val, 0 = clear) and value
//   abort             synchronous cancel of the running command
//   inc_req           single AC increment request while idle
//   op_valid/op_ready operand-pair handshake with the fetch unit
//   ac_q              AC data_out
//   ac_rst, ac_write_en, ac_alu_to_ac, ac_incre, ac_data   AC control/data_in
//   idx               index of the next pair to accept
//   busy, done, result  status, completion pulse, final AC value
`timescale 1ns/1ps

module ac_sequencer #(
    parameter int unsigned WORD  = 24,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             init_en,
    input  logic [WORD-1:0]  init_val,
    input  logic             abort,
    input  logic             inc_req,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WORD-1:0]  ac_q,
    output logic             ac_rst,
    output logic             ac_write_en,
    output logic             ac_alu_to_ac,
    output logic             ac_incre,
    output logic [WORD-1:0]  ac_data,
    output logic [CNT_W-1:0] idx,
    output logic             busy,
    output logic             done,
    output logic [WORD-1:0]  result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WAIT_OP,
        S_ACC,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             init_en_q, init_en_d;
    logic [WORD-1:0]  init_val_q, init_val_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [WORD-1:0]  result_q, result_d;
    logic             abort_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            init_en_q  <= 1'b0;
            init_val_q <= '0;
            idx_q      <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            init_en_q  <= init_en_d;
            init_val_q <= init_val_d;
            idx_q      <= idx_d;
            result_q   <= result_d;
        end
    end

    // Abort only cancels an in-flight command; IDLE and DONE ignore it.
    assign abort_hit = abort && (state_q != S_IDLE) && (state_q != S_DONE);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        init_en_d  = init_en_q;
        init_val_d = init_val_q;
        idx_d      = idx_q;
        result_d   = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d      = len;
                    init_en_d  = init_en;
                    init_val_d = init_val;
                    idx_d      = '0;
                    state_d    = S_INIT;
                end
            end
            S_INIT: begin
                state_d = (len_q != '0) ? S_WAIT_OP : S_DRAIN;
            end
            S_WAIT_OP: begin
                if (op_valid) begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                idx_d   = idx_q + CNT_W'(1);
                state_d = (idx_q == len_q - CNT_W'(1)) ? S_DRAIN : S_WAIT_OP;
            end
            S_DRAIN: begin
                result_d = ac_q;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_hit) begin
            state_d  = S_IDLE;
            idx_d    = idx_q;
            result_d = result_q;
        end
    end

    // AC strobes are suppressed in the abort cycle so a cancelled command
    // never touches AC on its way out.
    assign ac_rst       = (state_q == S_INIT) && !init_en_q && !abort_hit;
    assign ac_write_en  = (state_q == S_INIT) &&  init_en_q && !abort_hit;
    assign ac_alu_to_ac = (state_q == S_ACC) && !abort_hit;
    // The idle increment acts in the request cycle; it is qualified by rst so
    // that every output reads 0 while reset is held.
    assign ac_incre     = rst && (state_q == S_IDLE) && inc_req && !start;
    assign ac_data      = init_val_q;
    assign op_ready     = (state_q == S_WAIT_OP);
    assign idx          = idx_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign result       = result_q;

endmodule

// File: tb/tb_ac_sequencer.sv
// tb_ac_sequencer
//   Self-checking bench for ac_sequencer. A behavioural AC register/ALU sits
//   on the AC pins; each command's expected cycle schedule (INIT, per-pair
//   ACC cycles, DRAIN, DONE), idx and result are derived from the pair count,
//   the randomly chosen stall lengths and the operand sum.
`timescale 1ns/1ps

module tb_ac_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        init_en;
    logic [23:0] init_val;
    logic        abort;
    logic        inc_req;
    logic        op_valid;
    logic        op_ready;
    logic [23:0] ac_q;
    logic        ac_rst;
    logic        ac_write_en;
    logic        ac_alu_to_ac;
    logic        ac_incre;
    logic [23:0] ac_data;
    logic [7:0]  idx;
    logic        busy;
    logic        done;
    logic [23:0] result;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [23:0] prev_result;
    logic [23:0] op_mem [256];
    logic [23:0] ac_reg = '0;

    ac_sequencer #(.WORD(24), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .init_en(init_en),
        .init_val(init_val), .abort(abort), .inc_req(inc_req),
        .op_valid(op_valid), .op_ready(op_ready), .ac_q(ac_q),
        .ac_rst(ac_rst), .ac_write_en(ac_write_en),
        .ac_alu_to_ac(ac_alu_to_ac), .ac_incre(ac_incre), .ac_data(ac_data),
        .idx(idx), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // AC register and ALU: ALU output is AC plus the operand at idx.
    always @(posedge clk) begin
        if (ac_rst)            ac_reg <= '0;
        else if (ac_write_en)  ac_reg <= ac_data;
        else if (ac_alu_to_ac) ac_reg <= ac_reg + op_mem[idx];
        else if (ac_incre)     ac_reg <= ac_reg + 24'd1;
    end
    assign ac_q = ac_reg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] flags();
        return {op_ready, ac_rst, ac_write_en, ac_alu_to_ac, ac_incre, busy, done};
    endfunction

    // l: pair count; smin/smax: stall range before each pair; opmode 0 random
    // operands, 1 = 2,3,4,..., 2 = all ones; abort_c/restart_c: cycle to
    // assert abort / re-pulse start (0 = none); inc_busy: hold inc_req.
    task automatic run_cmd(input int l, input bit ien, input logic [23:0] ival,
                           input int smin, input int smax, input int opmode,
                           input int abort_c, input int restart_c, input bit inc_busy);
        int acc_c[256];
        int w, drain_c, done_c, lim, last_c, exp_idx;
        logic [23:0] exp_sum, exp_res;
        logic [6:0]  exp_f;
        bit is_acc, is_wait, want_valid;

        exp_sum = ien ? ival : 24'd0;
        w = 2;
        for (int p = 0; p < l; p++) begin
            case (opmode)
                1:       op_mem[p] = 24'(p + 2);
                2:       op_mem[p] = 24'd1;
                default: op_mem[p] = 24'($urandom);
            endcase
            exp_sum  += op_mem[p];
            acc_c[p] = w + int'($urandom_range(smax, smin)) + 1;
            w        = acc_c[p] + 1;
        end
        drain_c = (l == 0) ? 2 : acc_c[l-1] + 1;
        done_c  = drain_c + 1;
        lim     = (abort_c > 0) ? abort_c : done_c;
        last_c  = (abort_c > 0) ? abort_c + 3 : done_c + 1;

        @(negedge clk);
        start = 1'b1; len = 8'(l); init_en = ien; init_val = ival; inc_req = inc_busy;
        #1;
        if (inc_busy) check("incre_prio", 32'(ac_incre), 32'd0);
        @(posedge clk);
        #1;
        // Scramble command inputs: the sequencer must use its captured copies.
        start = 1'b0; len = 8'($urandom); init_en = ~ien; init_val = 24'($urandom);

        for (int c = 1; c <= last_c; c++) begin
            @(negedge clk);
            is_acc = 0; want_valid = 0; exp_idx = 0;
            for (int p = 0; p < l; p++) begin
                if (acc_c[p] == c)     is_acc = 1;
                if (acc_c[p] == c + 1) want_valid = 1;
                if (acc_c[p] < c && acc_c[p] <= lim) exp_idx++;
            end
            is_wait = (c <= lim) && (c > 1) && (c < drain_c) && !is_acc;
            if (c > lim) exp_f = '0;
            else exp_f = {is_wait, (c == 1) && !ien, (c == 1) && ien, is_acc,
                          1'b0, 1'b1, c == done_c};
            exp_res = (abort_c == 0 && c >= done_c) ? exp_sum : prev_result;

            check("flags", 32'(flags()), 32'(exp_f));
            check("idx", 32'(idx), 32'(exp_idx));
            check("result", 32'(result), 32'(exp_res));
            if (c == 1 && ien) check("ac_data", 32'(ac_data), 32'(ival));

            op_valid = is_wait ? want_valid : 1'($urandom_range(0, 1));
            abort    = (abort_c > 0) && (c == abort_c);
            start    = (restart_c > 0) && (c == restart_c);
            if (c == lim) inc_req = 1'b0;
        end
        start = 1'b0; abort = 1'b0; op_valid = 1'b0; inc_req = 1'b0;
        if (abort_c == 0) prev_result = exp_sum;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] ac_before;
        rst = 1'b0; start = 1'b0; len = '0; init_en = 1'b0; init_val = '0;
        abort = 1'b0; inc_req = 1'b0; op_valid = 1'b0;
        prev_result = '0;
        #2;
        check("rst_flags", 32'(flags()), 32'd0);
        check("rst_idx", 32'(idx), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_ac_data", 32'(ac_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Basic: clear, +2 +3 +4 -> 9, done in cycle 9
        run_cmd(3, 1'b0, 24'h0, 0, 0, 1, 0, 0, 1'b0);
        check("basic_result", 32'(result), 32'd9);
        // Preload 0x10 then +1 +1 -> 0x12, done in cycle 7
        run_cmd(2, 1'b1, 24'h000010, 0, 0, 2, 0, 0, 1'b0);
        check("preload_result", 32'(result), 32'h12);
        // Zero length
        run_cmd(0, 1'b0, 24'h0, 0, 0, 0, 0, 0, 1'b0);
        check("zero_result", 32'(result), 32'd0);
        // Two stall cycles before each pair -> done in cycle 11
        run_cmd(2, 1'b1, 24'h000100, 2, 2, 0, 0, 0, 1'b0);
        // Re-pulsed start in cycle 2, abort in the second WAIT_OP (cycle 4)
        run_cmd(4, 1'b1, 24'h00ABCD, 0, 0, 0, 4, 2, 1'b0);

        // Idle increments: exactly the two requested cycles
        @(negedge clk);
        ac_before = ac_q;
        inc_req = 1'b1;
        #1 check("incre_1", 32'(ac_incre), 32'd1);
        @(negedge clk);
        #1 check("incre_2", 32'(ac_incre), 32'd1);
        @(negedge clk);
        inc_req = 1'b0;
        #1 check("incre_off", 32'(ac_incre), 32'd0);
        check("incre_ac", 32'(ac_q), 32'(ac_before + 24'd2));

        // inc_req held while busy gives no pulse
        run_cmd(3, 1'b1, 24'($urandom), 0, 1, 0, 0, 0, 1'b1);

        // Randomised commands, then the maximum count
        for (int n = 0; n < 25; n++) begin
            run_cmd(int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)),
                    24'($urandom), 0, 2, 0, 0, 0, 1'b0);
        end
        run_cmd(255, 1'b1, 24'($urandom), 0, 0, 0, 0, 0, 1'b0);

        // Async reset in the middle of the second ACC cycle
        @(negedge clk);
        start = 1'b1; len = 8'd3; init_en = 1'b0; init_val = 24'h5A5A5A;
        @(posedge clk);
        #1 start = 1'b0; op_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_pre_acc", 32'(ac_alu_to_ac), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_flags", 32'(flags()), 32'd0);
        check("async_idx", 32'(idx), 32'd0);
        check("async_result", 32'(result), 32'd0);
        check("async_ac_data", 32'(ac_data), 32'd0);
        op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        prev_result = '0;
        run_cmd(int'($urandom_range(1, 5)), 1'b0, 24'h0, 0, 1, 0, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
